// File: rtl/irq_gateway_arbiter.sv
// -----------------------------------------------------------------------------
// irq_gateway_arbiter
//
// Per-source interrupt gateway plus a round-robin arbiter that feeds one
// registered valid/ready claim port. Each source moves through three states,
// IDLE -> PENDING -> INFLIGHT -> IDLE, so a source never has more than one
// interrupt in flight. PENDING sources are granted fairly, scanning upward
// from a rotating pointer.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous, active-high reset
//   src_irq        [NSRC] level interrupt request per source
//   src_en         [NSRC] per-source enable
//   claim_valid    a claim ID is presented
//   claim_id       [IDW] ID of the presented source
//   claim_ready    consumer accepts the claim this cycle
//   complete_valid handler-completion strobe
//   complete_id    [IDW] ID being completed
//   pending        [NSRC] per-source PENDING state
//   inflight       [NSRC] per-source INFLIGHT state
// -----------------------------------------------------------------------------
module irq_gateway_arbiter #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] src_en,
  output logic            claim_valid,
  output logic [IDW-1:0]  claim_id,
  input  logic            claim_ready,
  input  logic            complete_valid,
  input  logic [IDW-1:0]  complete_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] inflight
);

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_INFLIGHT
  } gw_state_e;

  gw_state_e       gw_q [NSRC];
  gw_state_e       gw_d [NSRC];

  logic            claim_valid_q, claim_valid_d;
  logic [IDW-1:0]  claim_id_q, claim_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            handshake;
  logic [NSRC-1:0] presented;
  logic [NSRC-1:0] eligible;
  logic            win_found;
  logic [IDW-1:0]  win_id;

  assign handshake = claim_valid_q & claim_ready;

  // A presented source is either held stable or is the one being accepted this
  // cycle; both cases must be kept out of the scan. Sources whose enable is
  // low are leaving PENDING at this edge, so they cannot win either.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      presented[i] = claim_valid_q && (int'(claim_id_q) == i);
      eligible[i]  = (gw_q[i] == GW_PENDING) && src_en[i] && !presented[i];
    end
  end

  // Round-robin scan starting at the pointer, wrapping modulo NSRC.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(ptr_q) + k) % NSRC;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Gateway next-state logic.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      gw_d[i] = gw_q[i];
      unique case (gw_q[i])
        GW_IDLE: begin
          if (src_irq[i] && src_en[i]) gw_d[i] = GW_PENDING;
        end
        GW_PENDING: begin
          if (handshake && presented[i])       gw_d[i] = GW_INFLIGHT;
          else if (!src_en[i] && !presented[i]) gw_d[i] = GW_IDLE;
        end
        GW_INFLIGHT: begin
          // IDs that do not map to an INFLIGHT source never match here.
          if (complete_valid && (int'(complete_id) == i)) gw_d[i] = GW_IDLE;
        end
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // Claim register and pointer next-state logic.
  always_comb begin
    claim_valid_d = claim_valid_q;
    claim_id_d    = claim_id_q;
    ptr_d         = ptr_q;
    if (!claim_valid_q || handshake) begin
      claim_valid_d = win_found;
      if (win_found) claim_id_d = win_id;
    end
    if (handshake) begin
      ptr_d = (int'(claim_id_q) == NSRC - 1) ? '0 : claim_id_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) gw_q[i] <= GW_IDLE;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      ptr_q         <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) gw_q[i] <= gw_d[i];
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      ptr_q         <= ptr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      pending[i]  = (gw_q[i] == GW_PENDING);
      inflight[i] = (gw_q[i] == GW_INFLIGHT);
    end
  end

  assign claim_valid = claim_valid_q;
  assign claim_id    = claim_id_q;

endmodule

// File: tb/tb_irq_gateway_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_gateway_arbiter
//
// Self-checking bench for irq_gateway_arbiter (NSRC=4, IDW=2). Expected claim
// IDs are queued as stimulus is driven and compared whenever the bench sees a
// handshake; gateway state and claim-port holding are checked directly.
// -----------------------------------------------------------------------------
module tb_irq_gateway_arbiter;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic [NSRC-1:0] src_en;
  logic            claim_valid;
  logic [IDW-1:0]  claim_id;
  logic            claim_ready;
  logic            complete_valid;
  logic [IDW-1:0]  complete_id;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] inflight;

  int unsigned exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  irq_gateway_arbiter #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clock          (clock),
    .reset          (reset),
    .src_irq        (src_irq),
    .src_en         (src_en),
    .claim_valid    (claim_valid),
    .claim_id       (claim_id),
    .claim_ready    (claim_ready),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .pending        (pending),
    .inflight       (inflight)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard hook: a handshake about to be sampled pops the next expected ID.
  task automatic step();
    if (!reset && claim_valid === 1'b1 && claim_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_claim", 32'(claim_id), 32'hffff);
      else                   check("claim_id", 32'(claim_id), exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    src_irq        = '0;
    claim_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_id    = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic complete(input logic [IDW-1:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
    step();
    complete_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IDW-1:0] last_id;
    logic           last_v;

    src_en = 4'hF;
    do_reset();
    check("rst_pending", 32'(pending), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_claim_valid", 32'(claim_valid), 0);
    check("rst_claim_id", 32'(claim_id), 0);

    // 1: single source, presented and held while not accepted.
    src_irq = 4'b0100;
    step();
    check("t1_pending", 32'(pending), 32'b0100);
    check("t1_no_claim_yet", 32'(claim_valid), 0);
    step();
    check("t1_claim_valid", 32'(claim_valid), 1);
    check("t1_claim_id", 32'(claim_id), 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_hold_valid", 32'(claim_valid), 1);
      check("t1_hold_id", 32'(claim_id), 2);
    end

    // 2: accept, stay INFLIGHT with irq still high, complete, re-pend.
    exp_q.push_back(2);
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    check("t2_inflight", 32'(inflight), 32'b0100);
    check("t2_pending", 32'(pending), 0);
    check("t2_claim_valid", 32'(claim_valid), 0);
    for (int i = 0; i < 3; i++) step();
    check("t2_still_inflight", 32'(inflight), 32'b0100);
    check("t2_no_reclaim", 32'(claim_valid), 0);
    complete(2);
    check("t2_idle_inflight", 32'(inflight), 0);
    check("t2_idle_pending", 32'(pending), 0);
    step();
    check("t2_repend", 32'(pending), 32'b0100);
    step();
    check("t2_reclaim_valid", 32'(claim_valid), 1);
    check("t2_reclaim_id", 32'(claim_id), 2);
    exp_q.push_back(2);
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    src_irq     = '0;
    complete(2);

    // 3: all sources, back-to-back claims, each completed one cycle later.
    do_reset();
    src_irq = 4'hF;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NSRC; i++) exp_q.push_back(i);
    claim_ready = 1'b1;
    last_v  = 1'b0;
    last_id = '0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      complete_valid = last_v;
      complete_id    = last_id;
      last_v  = claim_valid & claim_ready;
      last_id = claim_id;
      step();
    end
    check("t3_seq_drained", exp_q.size(), 0);
    claim_ready = 1'b0;
    src_irq     = '0;
    complete_valid = last_v;
    complete_id    = last_id;
    step();
    complete_valid = 1'b0;

    // 4: pointer at 2, sources 0 and 3 pending -> 3 then 0.
    do_reset();
    src_irq = 4'b0010;
    step();
    step();
    exp_q.push_back(1);
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    src_irq     = '0;
    complete(1);
    src_irq = 4'b1001;
    step();
    check("t4_pending", 32'(pending), 32'b1001);
    step();
    check("t4_first_id", 32'(claim_id), 3);
    exp_q.push_back(3);
    exp_q.push_back(0);
    claim_ready = 1'b1;
    step();
    step();
    claim_ready = 1'b0;
    src_irq     = '0;
    check("t4_drained", exp_q.size(), 0);
    check("t4_inflight", 32'(inflight), 32'b1001);
    complete(3);
    complete(0);

    // 5a: source 1 pending but not presented, disabled -> dropped.
    do_reset();
    src_irq = 4'b0011;
    step();
    step();
    check("t5_presented0", 32'(claim_id), 0);
    src_en  = 4'b1101;
    src_irq = '0;
    step();
    check("t5_dropped", 32'(pending), 32'b0001);
    exp_q.push_back(0);
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    step();
    step();
    check("t5_no_claim1", 32'(claim_valid), 0);
    src_en = 4'hF;
    complete(0);

    // 5b: source 1 presented, then disabled -> claim kept until accepted.
    src_irq = 4'b0010;
    step();
    step();
    src_en  = 4'b1101;
    src_irq = '0;
    for (int i = 0; i < 3; i++) step();
    check("t5_kept_valid", 32'(claim_valid), 1);
    check("t5_kept_id", 32'(claim_id), 1);
    check("t5_kept_pending", 32'(pending), 32'b0010);
    exp_q.push_back(1);
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    check("t5_inflight", 32'(inflight), 32'b0010);
    src_en = 4'hF;
    complete(1);

    // 6: stray complete ignored; reset while a claim is presented.
    do_reset();
    src_irq = 4'b0001;
    step();
    step();
    src_irq = '0;
    complete(3);
    check("t6_stray_pending", 32'(pending), 32'b0001);
    check("t6_stray_inflight", 32'(inflight), 0);
    check("t6_stray_valid", 32'(claim_valid), 1);
    check("t6_stray_id", 32'(claim_id), 0);
    reset       = 1'b1;
    claim_ready = 1'b1;
    step();
    reset       = 1'b0;
    claim_ready = 1'b0;
    check("t6_rst_valid", 32'(claim_valid), 0);
    check("t6_rst_pending", 32'(pending), 0);
    check("t6_rst_inflight", 32'(inflight), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_gateway_arbiter.md
Name: irq_gateway_arbiter

Overview:
- Per-source interrupt gateway and round-robin arbiter between level-sensitive interrupt wires and a single claim/complete interface toward the core's interrupt controller.
- Each source has a three-state gateway, so only one interrupt per source is ever in flight.
- Pending sources are granted fairly through a registered valid/ready claim port.
- Replaces the direct wire pass-through of interrupt lines with sequenced delivery.

Parameters:
- NSRC, 4, number of interrupt sources (2..16).
- IDW, 2, claim/complete ID width; must equal ceil(log2(NSRC)), minimum 1.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- src_irq  input  NSRC  level interrupt request per source.
- src_en  input  NSRC  per-source enable.
- claim_valid  output  1  a claim ID is presented.
- claim_id  output  IDW  ID of the presented source.
- claim_ready  input  1  consumer accepts the claim this cycle.
- complete_valid  input  1  handler-completion strobe.
- complete_id  input  IDW  ID being completed.
- pending  output  NSRC  per-source PENDING state.
- inflight  output  NSRC  per-source INFLIGHT state.

Behaviour:
- Reset is synchronous and active-high; clock is the only clock. All state is updated on the rising edge of clock.
- Reset values: all gateways IDLE; pending=0; inflight=0; claim_valid=0; claim_id=0; round-robin pointer=0.
- Per-source gateway FSM, states IDLE, PENDING, INFLIGHT:
  - IDLE->PENDING when src_irq[i]&src_en[i] is sampled high.
  - PENDING->INFLIGHT on claim handshake (claim_valid&claim_ready) with claim_id==i.
  - PENDING->IDLE when src_en[i] is low, unless i is the currently presented claim; a presented claim is never withdrawn.
  - INFLIGHT->IDLE on complete_valid with complete_id==i.
  - src_irq is ignored outside IDLE.
- Complete for an ID that is not INFLIGHT, or an ID >= NSRC: ignored, no state change.
- Claim register load: when claim_valid==0, or a handshake occurs this cycle, the register loads the arbitration winner.
  - Winner = first PENDING source scanning upward from the pointer, wrapping modulo NSRC.
  - The source accepted this cycle is excluded from the scan.
  - Sources currently presented are also excluded.
  - No eligible source: claim_valid=0 next cycle; claim_id holds its last value.
- Stability: while claim_valid&!claim_ready, claim_valid and claim_id hold stable.
- Pointer: on handshake, pointer = (claim_id+1) mod NSRC.
- Latency:
  - src_irq rises at edge n -> pending[i]=1 after edge n+1.
  - claim_valid=1 after edge n+2 if the arbiter is free.
  - Back-to-back claims are possible every cycle while sources are pending.
- Simultaneous complete and irq on the same source: the gateway goes IDLE at that edge. irq is re-sampled from IDLE at the next edge, giving one bubble cycle.
- Simultaneous handshake and complete on different IDs: both take effect independently.
- Reset asserted mid-handshake: all state returns to reset values next edge. Claims that were in flight are lost; software re-arms them.

Test Plan:
1. Reset; src_en=4'hF, src_irq=4'b0100 at edge 1, claim_ready=0 -> pending=4'b0100 after edge 2; claim_valid=1, claim_id=2 after edge 3; held stable 5 cycles.
2. From 1, claim_ready=1 for one cycle -> inflight=4'b0100, pending=0, claim_valid=0. Hold src_irq high -> no new claim until complete_valid=1, complete_id=2; then re-pend after 2 edges.
3. All four sources pending, claim_ready=1 continuously, complete each ID the cycle after its claim -> claim_id sequence 0,1,2,3 on consecutive cycles; after all re-pend, sequence restarts at 0.
4. Pointer=2 and sources 0 and 3 pending -> claim_id=3 first, then 0.
5. Source 1 pending but not presented, src_en[1]=0 -> pending[1]=0 next edge and no claim for 1. Repeat with 1 presented -> claim_id=1 stays valid until accepted.
6. complete_valid with complete_id=3 while source 3 is IDLE -> no state change. Assert reset while claim_valid=1 -> claim_valid=0, pending=0, inflight=0 after the edge.
